axi_sram_responder: RTL and testbench

- AXI4 responder (slave) terminating the core's AXI4 initiator interface onto one io_sram_* port of ram_wrapper.
- Lets an AXI-mastered bus (cache refill, DMA) reach BaseRAM/ExtRAM through the same word-level SRAM port the core drives directly.
- Serves one transaction at a time, either read or write, with INCR/FIXED bursts of up to 256 beats.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_sram_responder_if.sv | 50 +++++
 rtl/axi_burst_addr.sv | 12 +
 rtl/axi_sram_responder.sv | 112 +++++++++++
 tb/tb_axi_sram_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst codes, responder state encoding and shared defaults
package axi_pkg;
  localparam int ID_W_DEF = 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_DATA,
    S_WR_RESP
  } state_t;
  // unsupported WRAP bursts and beats wider than the 32-bit port are answered with SLVERR
  function automatic logic resp_err(input logic [1:0] burst, input logic [2:0] size);
    return burst == BURST_WRAP || size > 3'd2;
  endfunction
endpackage

// File: rtl/axi_sram_responder_if.sv
// axi_sram_responder_if: AXI4 ar/r/aw/w/b channels and the word-level SRAM port
// slave modport: responder view (AXI inputs, SRAM command outputs, sram_dout input)
// master modport: initiator plus SRAM-device view
interface axi_sram_responder_if #(
  parameter int ID_W    = 8,
  parameter int SRAM_AW = 20
);
  logic [ID_W-1:0]    ar_id;
  logic [31:0]        ar_addr;
  logic [7:0]         ar_len;
  logic [2:0]         ar_size;
  logic [1:0]         ar_burst;
  logic               ar_valid, ar_ready;
  logic [ID_W-1:0]    r_id;
  logic [31:0]        r_data;
  logic [1:0]         r_resp;
  logic               r_last, r_valid, r_ready;
  logic [ID_W-1:0]    aw_id;
  logic [31:0]        aw_addr;
  logic [7:0]         aw_len;
  logic [2:0]         aw_size;
  logic [1:0]         aw_burst;
  logic               aw_valid, aw_ready;
  logic [31:0]        w_data;
  logic [3:0]         w_strb;
  logic               w_last, w_valid, w_ready;
  logic [ID_W-1:0]    b_id;
  logic [1:0]         b_resp;
  logic               b_valid, b_ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_din, sram_dout;
  logic               sram_en, sram_re, sram_we;
  logic [3:0]         sram_wmask;
  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  w_data, w_strb, w_last, w_valid, b_ready, sram_dout,
    output ar_ready, r_id, r_data, r_resp, r_last, r_valid, aw_ready, w_ready,
    output b_id, b_resp, b_valid,
    output sram_addr, sram_din, sram_en, sram_re, sram_we, sram_wmask
  );
  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output w_data, w_strb, w_last, w_valid, b_ready, sram_dout,
    input  ar_ready, r_id, r_data, r_resp, r_last, r_valid, aw_ready, w_ready,
    input  b_id, b_resp, b_valid,
    input  sram_addr, sram_din, sram_en, sram_re, sram_we, sram_wmask
  );
endinterface

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next beat address for FIXED/INCR bursts (WRAP advances like INCR)
// addr/size/burst: current beat address and burst attributes; next: following beat address
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next
);
  assign next = burst == BURST_FIXED ? addr : addr + (32'd1 << size);
endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 slave serving one read or write burst at a time on a word-wide SRAM port
// clk, reset: system clock and synchronous active-high reset
// bus: AXI4 ar/r/aw/w/b channels plus sram_* command/data port (slave modport)
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int RD_WAIT = 1,
  parameter int SRAM_AW = 20
) (
  input logic clk,
  input logic reset,
  axi_sram_responder_if.slave bus
);
  state_t state, state_nx;
  logic rr, err, pend, done;
  logic [ID_W-1:0] id;
  logic [31:0] addr, addr_nx, rdata, din;
  logic [7:0] len, beat, wcnt;
  logic [2:0] size;
  logic [1:0] burst;
  logic [3:0] mask;
  logic ar_hs, aw_hs, r_hs, w_hs, b_hs, both, last_wait;
  axi_burst_addr u_addr (.addr(addr), .size(size), .burst(burst), .next(addr_nx));
  // rr=1 favours the write channel; it is consulted only when both address channels compete
  assign both      = bus.ar_valid && bus.aw_valid;
  assign ar_hs     = state == S_IDLE && bus.ar_valid && !(bus.aw_valid && rr);
  assign aw_hs     = state == S_IDLE && bus.aw_valid && !(bus.ar_valid && !rr);
  assign r_hs      = bus.r_valid && bus.r_ready;
  assign w_hs      = bus.w_ready && bus.w_valid;
  assign b_hs      = bus.b_valid && bus.b_ready;
  assign last_wait = wcnt == 8'(RD_WAIT - 1);
  assign bus.ar_ready   = ar_hs;
  assign bus.aw_ready   = aw_hs;
  assign bus.r_valid    = state == S_RD_RESP;
  assign bus.r_last     = bus.r_valid && beat == len;
  assign bus.r_resp     = bus.r_valid && err ? RESP_SLVERR : RESP_OKAY;
  assign bus.r_id       = id;
  assign bus.r_data     = rdata;
  assign bus.w_ready    = state == S_WR_DATA && !done;
  assign bus.b_valid    = state == S_WR_RESP;
  assign bus.b_resp     = bus.b_valid && err ? RESP_SLVERR : RESP_OKAY;
  assign bus.b_id       = id;
  assign bus.sram_re    = state == S_RD_CMD || state == S_RD_WAIT;
  assign bus.sram_we    = state == S_WR_DATA && pend;
  assign bus.sram_en    = bus.sram_re || bus.sram_we;
  assign bus.sram_addr  = addr[SRAM_AW+1:2];
  assign bus.sram_din   = din;
  assign bus.sram_wmask = mask;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = ar_hs ? S_RD_CMD : aw_hs ? S_WR_DATA : S_IDLE;
      S_RD_CMD:  state_nx = S_RD_WAIT;
      S_RD_WAIT: state_nx = last_wait ? S_RD_RESP : S_RD_WAIT;
      S_RD_RESP: state_nx = !r_hs ? S_RD_RESP : bus.r_last ? S_IDLE : S_RD_CMD;
      S_WR_DATA: state_nx = done ? S_WR_RESP : S_WR_DATA;
      S_WR_RESP: state_nx = b_hs ? S_IDLE : S_WR_RESP;
      default:   state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rr    <= 1'b0;
      err   <= 1'b0;
      pend  <= 1'b0;
      done  <= 1'b0;
      id    <= '0;
      addr  <= '0;
      rdata <= '0;
      din   <= '0;
      len   <= '0;
      beat  <= '0;
      wcnt  <= '0;
      size  <= '0;
      burst <= '0;
      mask  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= state == S_RD_WAIT ? wcnt + 8'd1 : 8'd0;
      pend  <= w_hs;
      if (ar_hs || aw_hs) begin
        id    <= ar_hs ? bus.ar_id : bus.aw_id;
        addr  <= ar_hs ? bus.ar_addr : bus.aw_addr;
        len   <= ar_hs ? bus.ar_len : bus.aw_len;
        size  <= ar_hs ? bus.ar_size : bus.aw_size;
        burst <= ar_hs ? bus.ar_burst : bus.aw_burst;
        err   <= ar_hs ? resp_err(bus.ar_burst, bus.ar_size) : resp_err(bus.aw_burst, bus.aw_size);
        beat  <= '0;
        done  <= 1'b0;
        // a lone request leaves the pointer alone so it cannot steal the next tie
        if (both) rr <= !rr;
      end
      if (state == S_RD_WAIT && last_wait) rdata <= bus.sram_dout;
      if (r_hs && !bus.r_last) begin
        beat <= beat + 8'd1;
        addr <= addr_nx;
      end
      // the beat count, not w_last, ends the burst; a disagreeing w_last only poisons the response
      if (w_hs) begin
        din  <= bus.w_data;
        mask <= bus.w_strb;
        beat <= beat + 8'd1;
        done <= beat == len;
        err  <= err || (bus.w_last != (beat == len));
      end
      // the write address advances as each registered command is issued
      if (bus.sram_we) addr <= addr_nx;
    end
  end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed and random AXI bursts checked against a behavioural memory model
module tb_axi_sram_responder;
  localparam int RDW = 2;
  typedef struct {
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    int          c;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0, cyc = 0, re_cycles = 0, inv_bad = 0;
  wr_t wq[$];
  logic [31:0] ref_mem[logic [19:0]];
  logic [7:0] ra_id, ra_len, wa_id, wa_len;
  logic [31:0] ra_addr, wa_addr;
  logic [2:0] ra_size, wa_size;
  logic [1:0] ra_burst, wa_burst;

  axi_sram_responder_if #(.ID_W(8), .SRAM_AW(20)) bus ();
  axi_sram_responder #(.ID_W(8), .RD_WAIT(RDW), .SRAM_AW(20)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_rd(input logic [19:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : {12'h0, w};
  endfunction
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu, input int i);
    return bu == 2'b00 ? a : a + 32'(i) * (32'd1 << sz);
  endfunction
  function automatic logic [1:0] exp_resp(input logic [1:0] bu, input logic [2:0] sz);
    return (bu == 2'b10 || sz > 3'd2) ? 2'b10 : 2'b00;
  endfunction

  // SRAM device: serves reads from the reference memory, logs every write command
  always @(negedge clk) begin
    if ((bus.sram_re && bus.sram_we) || bus.sram_en != (bus.sram_re || bus.sram_we)) inv_bad <= inv_bad + 1;
    if (bus.sram_re) re_cycles <= re_cycles + 1;
    if (bus.sram_we) wq.push_back('{bus.sram_addr, bus.sram_din, bus.sram_wmask, cyc});
    bus.sram_dout <= ref_rd(bus.sram_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.ar_ready, bus.aw_ready, bus.r_id, bus.r_data, bus.r_resp, bus.r_last, bus.r_valid,
             bus.w_ready, bus.b_id, bus.b_resp, bus.b_valid, bus.sram_addr, bus.sram_din,
             bus.sram_en, bus.sram_re, bus.sram_we, bus.sram_wmask};
  endfunction

  task automatic ar_drive(input logic [7:0] id, input logic [31:0] a, input logic [7:0] ln, input logic [2:0] sz, input logic [1:0] bu);
    ra_id = id; ra_addr = a; ra_len = ln; ra_size = sz; ra_burst = bu;
    bus.ar_id = id; bus.ar_addr = a; bus.ar_len = ln; bus.ar_size = sz; bus.ar_burst = bu;
    bus.ar_valid = 1'b1;
  endtask

  task automatic aw_drive(input logic [7:0] id, input logic [31:0] a, input logic [7:0] ln, input logic [2:0] sz, input logic [1:0] bu);
    wa_id = id; wa_addr = a; wa_len = ln; wa_size = sz; wa_burst = bu;
    bus.aw_id = id; bus.aw_addr = a; bus.aw_len = ln; bus.aw_size = sz; bus.aw_burst = bu;
    bus.aw_valid = 1'b1;
  endtask

  task automatic ar_wait();
    int n = 0;
    #1;
    while (!bus.ar_ready && n < 40) begin tick(); n++; end
    chk("ar_ready_timeout", 64'(n < 40), 1);
    tick();
    bus.ar_valid = 1'b0;
  endtask

  task automatic aw_wait();
    int n = 0;
    #1;
    while (!bus.aw_ready && n < 40) begin tick(); n++; end
    chk("aw_ready_timeout", 64'(n < 40), 1);
    tick();
    bus.aw_valid = 1'b0;
  endtask

  task automatic rd_beats(input int stall_beat, input int stall_n);
    for (int i = 0; i <= int'(ra_len); i++) begin
      int n;
      int re0;
      logic [31:0] a, d;
      n = 0;
      a = beat_addr(ra_addr, ra_size, ra_burst, i);
      d = ref_rd(a[21:2]);
      while (!bus.r_valid && n < 40) begin tick(); n++; end
      chk("r_latency", 64'(n), 64'(RDW + 1));
      chk("r_data", bus.r_data, d);
      chk("r_resp", bus.r_resp, exp_resp(ra_burst, ra_size));
      chk("r_last", bus.r_last, 64'(i == int'(ra_len)));
      chk("r_id", bus.r_id, ra_id);
      if (i == stall_beat) begin
        re0 = re_cycles;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk("r_stall_hold", {bus.r_valid, bus.r_last, bus.r_data}, {1'b1, 1'(i == int'(ra_len)), d});
        end
        chk("r_stall_no_read", 64'(re_cycles - re0), 0);
      end
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
    end
  endtask

  task automatic wr_beats(input logic [31:0] d0, input logic [3:0] m0, input int bad_last, input bit gaps);
    int n;
    logic [31:0] a, d, w;
    logic [3:0] m;
    wr_t exp_q[$];
    for (int i = 0; i <= int'(wa_len); i++) begin
      a = beat_addr(wa_addr, wa_size, wa_burst, i);
      d = i == 0 ? d0 : $urandom;
      m = i == 0 ? m0 : 4'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.w_valid = 1'b0;
        tick();
      end
      bus.w_data = d;
      bus.w_strb = m;
      bus.w_last = (i == int'(wa_len)) ^ (i == bad_last);
      bus.w_valid = 1'b1;
      n = 0;
      while (!bus.w_ready && n < 40) begin tick(); n++; end
      chk("w_ready_timeout", 64'(n < 40), 1);
      tick();
      exp_q.push_back('{a[21:2], d, m, 0});
      w = ref_rd(a[21:2]);
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[a[21:2]] = w;
    end
    bus.w_valid = 1'b0;
    bus.w_last = 1'b0;
    n = 0;
    while (!bus.b_valid && n < 40) begin tick(); n++; end
    chk("b_valid_timeout", 64'(n < 40), 1);
    chk("b_id", bus.b_id, wa_id);
    chk("b_resp", bus.b_resp, (bad_last >= 0 && bad_last <= int'(wa_len)) ? 2'b10 : exp_resp(wa_burst, wa_size));
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    chk("sram_write_count", 64'(wq.size()), 64'(exp_q.size()));
    for (int k = 0; k < wq.size() && k < exp_q.size(); k++) begin
      chk("sram_write_addr", wq[k].a, exp_q[k].a);
      chk("sram_write_data", wq[k].d, exp_q[k].d);
      chk("sram_write_mask", wq[k].m, exp_q[k].m);
    end
    if (!gaps && wq.size() == exp_q.size()) chk("sram_write_b2b", 64'(wq[wq.size()-1].c - wq[0].c), 64'(wa_len));
    wq.delete();
  endtask

  initial begin
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0; bus.ar_valid = 1'b0;
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
    bus.r_ready = 1'b0; bus.b_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("reset_outputs_zero", any_out(), 0);
    reset = 1'b0;
    tick();
    chk("idle_outputs_zero", any_out(), 0);
    // simultaneous requests: read first, then the next tie goes to the write
    ar_drive(8'h21, 32'h1000, 8'd0, 3'd2, 2'b01);
    aw_drive(8'h22, 32'h1100, 8'd0, 3'd2, 2'b01);
    #1;
    chk("arb1_ar_ready", bus.ar_ready, 1);
    chk("arb1_aw_ready", bus.aw_ready, 0);
    ar_wait();
    rd_beats(-1, 0);
    #1;
    chk("arb1_aw_after_read", bus.aw_ready, 1);
    aw_wait();
    wr_beats(32'h1234_5678, 4'hF, -1, 1'b0);
    ar_drive(8'h31, 32'h1200, 8'd0, 3'd2, 2'b01);
    aw_drive(8'h32, 32'h1300, 8'd0, 3'd2, 2'b01);
    #1;
    chk("arb2_ar_ready", bus.ar_ready, 0);
    chk("arb2_aw_ready", bus.aw_ready, 1);
    aw_wait();
    wr_beats(32'hCAFE_F00D, 4'hF, -1, 1'b0);
    ar_wait();
    rd_beats(-1, 0);
    // single-beat partial write
    aw_drive(8'h5A, 32'h100, 8'd0, 3'd2, 2'b01);
    aw_wait();
    wr_beats(32'hDEAD_BEEF, 4'b0011, -1, 1'b0);
    // INCR read of 4 words with a 5-cycle stall on the second beat
    ar_drive(8'h07, 32'h200, 8'd3, 3'd2, 2'b01);
    ar_wait();
    rd_beats(1, 5);
    // WRAP read and a write whose w_last comes early
    ar_drive(8'h08, 32'h300, 8'd1, 3'd2, 2'b10);
    ar_wait();
    rd_beats(-1, 0);
    aw_drive(8'h09, 32'h400, 8'd1, 3'd2, 2'b01);
    aw_wait();
    wr_beats(32'h0BAD_0BAD, 4'hF, 0, 1'b0);
    // missing w_last on the final beat, FIXED burst
    aw_drive(8'h0A, 32'h500, 8'd2, 3'd2, 2'b00);
    aw_wait();
    wr_beats(32'h1111_2222, 4'b1010, 2, 1'b0);
    // oversize beats, FIXED read, and an INCR read crossing the 32-bit wrap
    ar_drive(8'h0B, 32'h600, 8'd1, 3'd3, 2'b01);
    ar_wait();
    rd_beats(-1, 0);
    ar_drive(8'h0C, 32'h500, 8'd2, 3'd2, 2'b00);
    ar_wait();
    rd_beats(-1, 0);
    ar_drive(8'h0D, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01);
    ar_wait();
    rd_beats(-1, 0);
    // reset in the middle of a read burst
    ar_drive(8'h0E, 32'h700, 8'd7, 3'd2, 2'b01);
    ar_wait();
    tick();
    reset = 1'b1;
    tick();
    chk("midburst_reset_outputs_zero", any_out(), 0);
    reset = 1'b0;
    ar_drive(8'h0F, 32'h240, 8'd1, 3'd2, 2'b01);
    ar_wait();
    rd_beats(-1, 0);
    // random mix of reads and writes over a small region
    for (int t = 0; t < 40; t++) begin
      logic [2:0] sz;
      logic [1:0] bu;
      logic [7:0] ln;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 3));
      bu = 2'($urandom_range(0, 2));
      ln = 8'($urandom_range(0, 7));
      a = 32'h2000 + 32'($urandom_range(0, 63)) * 4 + (sz < 3'd2 ? 32'($urandom_range(0, 3)) : 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        ar_drive(8'($urandom), a, ln, sz, bu);
        ar_wait();
        rd_beats($urandom_range(0, int'(ln)), $urandom_range(0, 3));
      end else begin
        aw_drive(8'($urandom), a, ln, sz, bu);
        aw_wait();
        wr_beats($urandom, 4'($urandom), $urandom_range(0, 5) == 0 ? $urandom_range(0, int'(ln)) : -1, 1'($urandom));
      end
    end
    chk("sram_strobe_invariants", 64'(inv_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
